// File: rtl/mdu_hilo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_hilo_pkg
// Brief    : Shared operation codes and helpers for the HI/LO multiply/divide
//            unit. The MDUOP_* codes live next to the ALU op codes in the
//            EX-stage control decode.
// Revision : 1.0 - initial release
// ============================================================================
package mdu_hilo_pkg;

  localparam int OP_W = 3;

  // Encodings 3'd6 and 3'd7 are reserved; the unit ignores them.
  typedef enum logic [OP_W-1:0] {
    MDUOP_MULT  = 3'd0,
    MDUOP_MULTU = 3'd1,
    MDUOP_DIV   = 3'd2,
    MDUOP_DIVU  = 3'd3,
    MDUOP_MTHI  = 3'd4,
    MDUOP_MTLO  = 3'd5
  } mdu_op_e;

  // True for the operations that occupy the unit for several cycles.
  function automatic logic is_long_op(input logic [OP_W-1:0] op);
    return (op == MDUOP_MULT) || (op == MDUOP_MULTU) ||
           (op == MDUOP_DIV)  || (op == MDUOP_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_hilo_if.sv
`default_nettype none
// ============================================================================
// Module   : mdu_hilo_if
// Brief    : Request/result bundle between the EX stage and the MDU.
// Revision : 1.0 - initial release
// ============================================================================
interface mdu_hilo_if #(
  parameter int WIDTH = 32
) ();
  import mdu_hilo_pkg::*;

  logic             start;
  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             flush;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, A, B, flush,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, A, B, flush,
    output busy, hi, lo
  );

endinterface
`default_nettype wire

// File: rtl/mdu_div_core.sv
`default_nettype none
// ============================================================================
// Module   : mdu_div_core
// Brief    : Combinational signed/unsigned divider producing quotient and
//            remainder, with the architectural divide-by-zero and signed
//            overflow results applied explicitly.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  wire logic [WIDTH-1:0] i_a,       // dividend
  input  wire logic [WIDTH-1:0] i_b,       // divisor
  input  wire logic             i_signed,  // 1 = DIV, 0 = DIVU
  output logic      [WIDTH-1:0] o_quot,
  output logic      [WIDTH-1:0] o_rem
);

  localparam logic [WIDTH-1:0] c_most_neg = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] c_one      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_b_safe;
  logic [WIDTH-1:0] w_uq;
  logic [WIDTH-1:0] w_ur;
  logic             w_b_zero;
  logic             w_ovf;

  // Divide on magnitudes, then restore signs: quotient truncates toward zero
  // and the remainder follows the dividend.
  assign w_a_neg  = i_signed & i_a[WIDTH-1];
  assign w_b_neg  = i_signed & i_b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (~i_a + c_one) : i_a;
  assign w_b_mag  = w_b_neg ? (~i_b + c_one) : i_b;
  assign w_b_zero = (i_b == '0);
  // Keep the unsigned divider away from a zero divisor; its result is unused then.
  assign w_b_safe = w_b_zero ? c_one : w_b_mag;
  assign w_uq     = w_a_mag / w_b_safe;
  assign w_ur     = w_a_mag % w_b_safe;
  assign w_ovf    = i_signed && (i_a == c_most_neg) && (i_b == '1);

  // Pick the special-case result or the sign-corrected quotient/remainder.
  always_comb begin
    o_quot = (w_a_neg ^ w_b_neg) ? (~w_uq + c_one) : w_uq;
    o_rem  = w_a_neg ? (~w_ur + c_one) : w_ur;
    if (w_b_zero) begin
      o_quot = '1;
      o_rem  = i_a;
    end else if (w_ovf) begin
      o_quot = c_most_neg;
      o_rem  = '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mdu_hilo.sv
`default_nettype none
// ============================================================================
// Module   : mdu_hilo
// Brief    : Multiply/divide unit with architectural HI/LO registers. The
//            result is computed at acceptance and held as pending; a latency
//            counter models the multi-cycle unit and commits HI/LO when it
//            expires. Flush discards the pending result.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = 4
) (
  input  wire logic   clk,
  input  wire logic   reset_n,
  mdu_hilo_if.slave   bus
);

  localparam logic [CNT_W-1:0] c_mul_lat = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] c_div_lat = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_pend_hi;
  logic [WIDTH-1:0]   r_pend_lo;
  logic [CNT_W-1:0]   r_cnt;

  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_prod_u;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic               w_busy;
  logic               w_accept;

  // Full-width products; sign extension to 2*WIDTH makes the truncated
  // product equal to the signed result.
  assign w_prod_s = {{WIDTH{bus.A[WIDTH-1]}}, bus.A} * {{WIDTH{bus.B[WIDTH-1]}}, bus.B};
  assign w_prod_u = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};

  mdu_div_core #(
    .WIDTH (WIDTH)
  ) u_div (
    .i_a      (bus.A),
    .i_b      (bus.B),
    .i_signed (bus.op == MDUOP_DIV),
    .o_quot   (w_quot),
    .o_rem    (w_rem)
  );

  assign w_busy   = (r_cnt != '0);
  assign w_accept = bus.start && !w_busy && !bus.flush;

  assign bus.busy = w_busy;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

  // Accept requests, count down latency and commit pending results to HI/LO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_cnt     <= '0;
    end else if (bus.flush) begin
      r_cnt     <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
    end else if (w_busy) begin
      r_cnt <= r_cnt - c_cnt_one;
      if (r_cnt == c_cnt_one) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
    end else if (w_accept) begin
      case (bus.op)
        MDUOP_MULT: begin
          r_pend_hi <= w_prod_s[2*WIDTH-1:WIDTH];
          r_pend_lo <= w_prod_s[WIDTH-1:0];
        end
        MDUOP_MULTU: begin
          r_pend_hi <= w_prod_u[2*WIDTH-1:WIDTH];
          r_pend_lo <= w_prod_u[WIDTH-1:0];
        end
        MDUOP_DIV, MDUOP_DIVU: begin
          r_pend_hi <= w_rem;
          r_pend_lo <= w_quot;
        end
        MDUOP_MTHI: r_hi <= bus.A;
        MDUOP_MTLO: r_lo <= bus.A;
        default: ;
      endcase
      if (is_long_op(bus.op)) begin
        r_cnt <= ((bus.op == MDUOP_DIV) || (bus.op == MDUOP_DIVU)) ? c_div_lat : c_mul_lat;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_hilo.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_hilo
// Brief    : Self-checking bench for mdu_hilo: directed cases plus random
//            operations compared against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_hilo;
  import mdu_hilo_pkg::*;

  localparam int W       = 32;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  mdu_hilo_if #(.WIDTH(W)) bus ();

  mdu_hilo #(
    .WIDTH   (W),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Architectural result of one operation, from plain integer arithmetic.
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2, 3'd3: begin
        if (b == '0) begin
          m_lo = '1; m_hi = a;
        end else if (op == 3'd2) begin
          q = sa / sb; r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0];
        end else begin
          m_lo = a / b; m_hi = a % b;
        end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  function automatic int lat_of(input logic [2:0] op);
    if (op == 3'd0 || op == 3'd1) return MUL_LAT;
    if (op == 3'd2 || op == 3'd3) return DIV_LAT;
    return 0;
  endfunction

  // Issue one operation, wait for completion and check busy length and HI/LO.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    model(op, a, b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    while (bus.busy && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    check({tag, " busy_len"}, 64'(n), 64'(lat_of(op)));
    check({tag, " hi"}, 64'(bus.hi), 64'(m_hi));
    check({tag, " lo"}, 64'(bus.lo), 64'(m_lo));
  endtask

  initial begin
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;
    logic [W-1:0] save_hi, save_lo;
    checks = 0; failures = 0;
    m_hi = '0; m_lo = '0;
    reset_n = 1'b0;
    bus.start = 1'b0; bus.op = 3'd0; bus.A = '0; bus.B = '0; bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    @(negedge clk); reset_n = 1'b1;

    // Moves and the directed arithmetic cases
    run_op("mthi", 3'd4, 32'h0000_1234, 32'd0);
    run_op("mtlo", 3'd5, 32'h0000_ABCD, 32'd0);
    check("mt hi const", 64'(bus.hi), 64'h1234);
    run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3);
    check("mult lo const", 64'(bus.lo), 64'hFFFF_FFFA);
    run_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3);
    check("multu hi const", 64'(bus.hi), 64'h2);
    run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2);
    check("div lo const", 64'(bus.lo), 64'hFFFF_FFFD);
    run_op("divu", 3'd3, 32'd7, 32'd2);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf lo const", 64'(bus.lo), 64'h8000_0000);
    run_op("divu_zero", 3'd3, 32'd5, 32'd0);
    run_op("div_zero", 3'd2, 32'hFFFF_FF00, 32'd0);
    run_op("undef_op", 3'd6, 32'hDEAD_BEEF, 32'd1);
    run_op("undef_op7", 3'd7, 32'hDEAD_BEEF, 32'd1);

    // MTLO presented while a multiply is running must be dropped
    model(3'd0, 32'h0001_0003, 32'h0000_0007);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.A = 32'h0001_0003; bus.B = 32'h0000_0007;
    @(posedge clk); #1;
    bus.op = 3'd5; bus.A = 32'h5555_5555;
    repeat (2) @(posedge clk);
    #1;
    check("mtlo_busy lo held", 64'(bus.lo), 64'hFFFF_FFFF);
    bus.start = 1'b0;
    repeat (MUL_LAT) @(posedge clk);
    #1;
    check("mtlo_busy busy", 64'(bus.busy), 64'd0);
    check("mtlo_busy lo", 64'(bus.lo), 64'(m_lo));
    check("mtlo_busy hi", 64'(bus.hi), 64'(m_hi));

    // Flush in busy cycle 3 together with a start
    save_hi = bus.hi; save_lo = bus.lo;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.A = 32'h1234_5678; bus.B = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    bus.op = 3'd4;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.start = 1'b0;
    check("flush busy", 64'(bus.busy), 64'd0);
    repeat (MUL_LAT + 2) @(posedge clk);
    #1;
    check("flush hi kept", 64'(bus.hi), 64'(save_hi));
    check("flush lo kept", 64'(bus.lo), 64'(save_lo));

    // Flush on the edge that would commit a divide
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd3; bus.A = 32'd100; bus.B = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (DIV_LAT - 1) @(posedge clk);
    @(negedge clk);
    check("flush_last still busy", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_last busy", 64'(bus.busy), 64'd0);
    check("flush_last hi", 64'(bus.hi), 64'(save_hi));
    check("flush_last lo", 64'(bus.lo), 64'(save_lo));

    // Flush while idle changes nothing
    @(negedge clk); bus.flush = 1'b1;
    @(posedge clk); #1; bus.flush = 1'b0;
    check("flush_idle hi", 64'(bus.hi), 64'(save_hi));
    check("flush_idle busy", 64'(bus.busy), 64'd0);

    // Random operations against the model, issued back-to-back
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 5));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = '0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op("random", rop, ra, rb);
    end

    // Asynchronous reset in the middle of a divide
    run_op("pre_reset", 3'd5, 32'hCAFE_F00D, 32'd0);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd2; bus.A = 32'hFFFF_0000; bus.B = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset busy", 64'(bus.busy), 64'd0);
    check("async_reset hi", 64'(bus.hi), 64'd0);
    check("async_reset lo", 64'(bus.lo), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    repeat (DIV_LAT + 2) @(posedge clk);
    #1;
    check("post_reset lo", 64'(bus.lo), 64'd0);
    check("post_reset busy", 64'(bus.busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Parametrised multiply/divide unit with architectural HI/LO registers; the multi-cycle companion to the single-cycle ALU in the EX stage.
- Accepts signed/unsigned multiply and divide plus direct HI/LO writes.
- Models fixed per-operation latency with a busy flag that the hazard unit uses to stall later HI/LO consumers.
- Supports abort on pipeline flush.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_LAT, 5, cycles busy for MULT/MULTU (min 1).
- DIV_LAT, 10, cycles busy for DIV/DIVU (min 1).
- CNT_W, 4, latency counter width; must hold max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request valid this cycle.
- op  in  3  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- A  in  WIDTH  rs operand (dividend / multiplicand / MT data).
- B  in  WIDTH  rt operand (divisor / multiplier).
- flush  in  1  abort in-flight operation.
- busy  out  1  multi-cycle operation in progress.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: hi=0, lo=0, busy=0, counter=0, pending result=0. Reset asserted mid-operation clears everything immediately, with no commit.
- Acceptance: start is sampled on the rising edge and is accepted only if busy=0 and flush=0. While busy=1, start is ignored; upstream must stall. An undefined op value is ignored.
- MTHI/MTLO: single cycle. hi (or lo) = A at the accepting edge; busy stays 0.
- MULT/MULTU/DIV/DIVU timing:
  - At the accepting edge, the full result is computed and latched into pending_hi/pending_lo, and the counter is loaded with MUL_LAT or DIV_LAT.
  - busy = (counter != 0); it is a registered output and goes high in the cycle after acceptance.
  - Each edge with counter != 0 decrements the counter. On the edge where the counter goes 1->0, hi/lo take the pending values.
  - Net effect: busy is high for exactly LAT cycles, and new hi/lo are visible in the first cycle busy=0.
  - Back-to-back: a new start can be accepted in that first busy=0 cycle.
- Multiply:
  - MULT takes the signed 2*WIDTH product; MULTU the unsigned product.
  - hi = product[2W-1:W], lo = product[W-1:0].
- Divide:
  - lo = quotient, hi = remainder.
  - Signed DIV truncates the quotient toward zero; the remainder takes the sign of the dividend.
  - DIVU is unsigned.
  - Divide by zero (signed or unsigned): lo = all ones, hi = A.
  - Signed overflow (A = most-negative, B = -1): lo = most-negative, hi = 0.
- Flush:
  - flush=1 at an edge clears the counter and discards the pending result; hi/lo are unchanged.
  - flush and start in the same cycle: start is ignored.
  - flush on the same edge the counter would reach 0: flush wins, no commit.
  - flush while idle: no effect.
- Reads: hi/lo outputs are direct register values. There is no forwarding of pending results; the hazard unit stalls MFHI/MFLO while busy=1.
- Widths: all arithmetic is at WIDTH; products are computed at 2*WIDTH before splitting.

Decomposition:
- Shared constants: MDUOP_MULT, MDUOP_MULTU, MDUOP_DIV, MDUOP_DIVU, MDUOP_MTHI, MDUOP_MTLO, added alongside the existing ALUOP_* definitions in the shared control signal-definition include.
- Sub-module: mdu_div_core, a combinational signed/unsigned quotient/remainder with the divide-by-zero and overflow rules. It keeps the special cases isolated for unit test.
- The latency counter and HI/LO registers stay in the top module.

Test Plan:
- Reset, then MTHI A=0x1234 followed by MTLO A=0xABCD -> hi=0x00001234, lo=0x0000ABCD one cycle later; busy never asserts.
- MULT A=0xFFFFFFFE (-2), B=3 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV A=-7 (0xFFFFFFF9), B=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1.
- Boundaries:
  - DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
  - DIVU A=5, B=0 -> lo=0xFFFFFFFF, hi=5.
- MULT issued, then start with MTLO while busy -> lo not written by the MTLO; after completion, lo = the product low word.
- MULT issued, flush at busy cycle 3 -> busy=0 next cycle and hi/lo keep pre-MULT values. Separately: reset_n pulsed low mid-DIV -> all outputs 0 immediately.
